// File: rtl/slot_stock_scanner.sv
// Scans the four slot-status mux inputs in turn and publishes a registered stock mask.
// Optional AUTO_RESCAN_EN: after each result the scanner restarts on its own instead of idling.
module slot_stock_scanner #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mux_y,
    output logic [1:0] mux_sel,
    output logic       busy,
    output logic       done,
    output logic [3:0] stock_mask,
    output logic [2:0] empty_count,
    output logic       any_empty
);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

    state_e     state;
    logic [3:0] cnt;
    logic [2:0] shadow;
    logic [3:0] new_mask;
    logic [2:0] new_empty;

    // The slot-3 sample is taken on the same edge the result is published.
    always_comb begin
        new_mask  = {mux_y, shadow};
        new_empty = 3'd0;
        for (int i = 0; i < 4; i++) begin
            new_empty = new_empty + {2'b00, ~new_mask[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= StIdle;
            mux_sel     <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            stock_mask  <= 4'b1111;
            empty_count <= 3'd0;
            any_empty   <= 1'b0;
            cnt         <= 4'd0;
            shadow      <= 3'd0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state   <= StSettle;
                        mux_sel <= 2'd0;
                        cnt     <= 4'd0;
                        busy    <= 1'b1;
                    end
                end
                StSettle: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == SettleLast) begin
                        state <= StSample;
                    end
                end
                StSample: begin
                    if (mux_sel == 2'd3) begin
                        stock_mask  <= new_mask;
                        empty_count <= new_empty;
                        any_empty   <= (new_empty != 3'd0);
                        done        <= 1'b1;
                        state       <= StDone;
                    end else begin
                        shadow[mux_sel] <= mux_y;
                        mux_sel         <= mux_sel + 2'd1;
                        cnt             <= 4'd0;
                        state           <= StSettle;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    mux_sel <= 2'd0;
`ifdef AUTO_RESCAN_EN
                    cnt     <= 4'd0;
                    state   <= StSettle;
`else
                    busy    <= 1'b0;
                    state   <= StIdle;
`endif
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_slot_stock_scanner.sv
// Directed bench for slot_stock_scanner: one instance with SETTLE_CYCLES=1, one with 3.
// Honours AUTO_RESCAN_EN when the design is built with it.
module tb_slot_stock_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start3 = 1'b0;
    logic [3:0] d1 = 4'b0000, d3 = 4'b0000;
    logic       y1, y3;
    logic [1:0] sel1, sel3;
    logic       busy1, busy3, done1, done3, ae1, ae3;
    logic [3:0] mask1, mask3;
    logic [2:0] ec1, ec3;

    int total = 0;
    int bad = 0;
    bit slow = 1'b0;

    logic [1:0] o_sel;
    logic       o_busy, o_done, o_ae;
    logic [3:0] o_mask;
    logic [2:0] o_ec;

    always #5 clk = ~clk;

    // Combinational mux model: mux_y = D[mux_sel]
    assign y1 = d1[sel1];
    assign y3 = d3[sel3];

    slot_stock_scanner #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mux_y(y1), .mux_sel(sel1),
        .busy(busy1), .done(done1), .stock_mask(mask1), .empty_count(ec1), .any_empty(ae1)
    );

    slot_stock_scanner #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .mux_y(y3), .mux_sel(sel3),
        .busy(busy3), .done(done3), .stock_mask(mask3), .empty_count(ec3), .any_empty(ae3)
    );

    always_comb begin
        o_sel  = slow ? sel3  : sel1;
        o_busy = slow ? busy3 : busy1;
        o_done = slow ? done3 : done1;
        o_mask = slow ? mask3 : mask1;
        o_ec   = slow ? ec3   : ec1;
        o_ae   = slow ? ae3   : ae1;
    end

    typedef struct {
        bit         slow;
        logic [3:0] d;
        logic [3:0] mask;
        int         ecnt;
        int         any;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; the start is accepted at the following posedge.
    task automatic pulse_start(input bit s);
        @(negedge clk);
        if (s) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int k);
        k = 0;
        while (!o_done && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (!o_done) chk("done_timeout", 0, 1);
    endtask

    task automatic after_done();
`ifdef AUTO_RESCAN_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`else
        @(negedge clk);
        chk("busy_after_done", int'(o_busy), 0);
        chk("done_one_cycle", int'(o_done), 0);
`endif
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (o_done) n++;
        end
    endtask

    initial begin
        int k, kk, n;

        vecs[0] = '{1'b0, 4'b0101, 4'b0101, 2, 1};
        vecs[1] = '{1'b1, 4'b1010, 4'b1010, 2, 1};
        vecs[2] = '{1'b0, 4'b1111, 4'b1111, 0, 0};
        vecs[3] = '{1'b1, 4'b0000, 4'b0000, 4, 1};
        vecs[4] = '{1'b0, 4'b1110, 4'b1110, 1, 1};
        vecs[5] = '{1'b1, 4'b0001, 4'b0001, 3, 1};

        // Reset for two edges, then release
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mask1", int'(mask1), 15);
        chk("rst_ec1", int'(ec1), 0);
        chk("rst_ae1", int'(ae1), 0);
        chk("rst_busy1", int'(busy1), 0);
        chk("rst_done1", int'(done1), 0);
        chk("rst_sel1", int'(sel1), 0);
        chk("rst_mask3", int'(mask3), 15);
        chk("rst_busy3", int'(busy3), 0);

        // Table-driven scans
        foreach (vecs[i]) begin
            slow = vecs[i].slow;
            if (slow) d3 = vecs[i].d; else d1 = vecs[i].d;
            pulse_start(slow);
            chk("busy_after_accept", int'(o_busy), 1);
            wait_done(100, k);
            chk("latency", k, slow ? 16 : 8);
            chk("mask", int'(o_mask), int'(vecs[i].mask));
            chk("empty_count", int'(o_ec), vecs[i].ecnt);
            chk("any_empty", int'(o_ae), vecs[i].any);
            after_done();
        end

        // Select sequencing with SETTLE_CYCLES=3: each slot held 4 cycles
        slow = 1'b1;
        d3 = 4'b1010;
        pulse_start(1'b1);
        for (int t = 0; t < 16; t++) begin
            chk("sel_step", int'(sel3), t / 4);
            @(negedge clk);
        end
        chk("seq_done16", int'(done3), 1);
        chk("seq_mask", int'(mask3), 10);
        after_done();

        // A second start mid-scan is ignored
        slow = 1'b0;
        d1 = 4'b1111;
        pulse_start(1'b0);
        repeat (3) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(100, kk);
        chk("ign_latency", kk + 4, 8);
        chk("ign_mask", int'(mask1), 15);
        chk("ign_ec", int'(ec1), 0);
        chk("ign_ae", int'(ae1), 0);
`ifdef AUTO_RESCAN_EN
        after_done();
`else
        count_dones(20, n);
        chk("ign_single_done", n, 0);
`endif

        // Slot-3 data changes while selected, before its sample
        slow = 1'b1;
        d3 = 4'b0000;
        pulse_start(1'b1);
        repeat (12) @(negedge clk);
        chk("chg_sel3", int'(sel3), 3);
        d3 = 4'b1000;
        wait_done(100, kk);
        chk("chg_latency", kk + 12, 16);
        chk("chg_mask", int'(mask3), 8);
        chk("chg_ec", int'(ec3), 3);
        chk("chg_ae", int'(ae3), 1);
        after_done();

        // Reset mid-scan discards the partial result
        slow = 1'b0;
        d1 = 4'b0101;
        pulse_start(1'b0);
        wait_done(100, k);
        chk("pre_mask", int'(mask1), 5);
        after_done();
        d1 = 4'b0000;
        pulse_start(1'b0);
        repeat (4) @(negedge clk);
        chk("mid_sel2", int'(sel1), 2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_busy", int'(busy1), 0);
        chk("mid_mask", int'(mask1), 15);
        chk("mid_sel", int'(sel1), 0);
        chk("mid_done", int'(done1), 0);
        count_dones(20, n);
        chk("mid_no_done", n, 0);

        // Start held high: retrigger period (10 idle-returning, 9 auto-rescan)
        slow = 1'b0;
        d1 = 4'b0110;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        wait_done(100, k);
        chk("held_first", k, 8);
        chk("held_mask", int'(mask1), 6);
        @(negedge clk);
`ifndef AUTO_RESCAN_EN
        chk("held_idle_gap", int'(busy1), 0);
`endif
        wait_done(100, kk);
`ifdef AUTO_RESCAN_EN
        chk("held_period", kk + 1, 9);
`else
        chk("held_period", kk + 1, 10);
`endif
        start1 = 1'b0;
        after_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
